// File: rtl/alu_issue_stage.sv
// Decode-and-issue stage feeding the execute ALU: RV32I decode into ALU control/operands,
// registered ID/EX output with a one-entry skid buffer so in_ready never depends on out_ready.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    output logic        is_branch,
    output logic        illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic        br;
        logic        ill;
    } bundle_t;

    localparam bundle_t BUNDLE_ZERO = '{a: 32'd0, b: 32'd0, ctrl: 4'b0000, br: 1'b0, ill: 1'b0};

    // Shared R/I-ALU funct3 mapping; funct7b5 picks sub/sra variants
    function automatic logic [3:0] alu_op_f(input logic [2:0] f3, input logic f7b5);
        logic [3:0] op;
        case (f3)
            3'b000:  op = f7b5 ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic       funct7b5_s;
    logic       unused_instr_s;
    bundle_t    dec_s;

    assign opcode_s       = instr[6:0];
    assign funct3_s       = instr[14:12];
    assign funct7b5_s     = instr[30];
    assign unused_instr_s = ^{instr[31], instr[29:15], instr[11:7]};

    // Combinational decode of the incoming bundle
    always_comb begin
        dec_s = '{a: rs1_data, b: imm, ctrl: ALU_ADD, br: 1'b0, ill: 1'b0};
        case (opcode_s)
            OP_R: begin
                dec_s.b    = rs2_data;
                dec_s.ctrl = alu_op_f(funct3_s, funct7b5_s);
            end
            OP_IALU: begin
                dec_s.ctrl = (funct3_s == 3'b000) ? ALU_ADD : alu_op_f(funct3_s, funct7b5_s);
                dec_s.ill  = (funct3_s == 3'b001) & funct7b5_s;
            end
            OP_BRANCH: begin
                dec_s.b  = rs2_data;
                dec_s.br = 1'b1;
                case (funct3_s[2:1])
                    2'b00:   dec_s.ctrl = ALU_SUB;
                    2'b10:   dec_s.ctrl = ALU_SLT;
                    2'b11:   dec_s.ctrl = ALU_SLTU;
                    default: dec_s.ill  = 1'b1;
                endcase
            end
            OP_LUI:                     dec_s.a = 32'd0;
            OP_AUIPC, OP_JAL:           dec_s.a = pc;
            OP_LOAD, OP_STORE, OP_JALR: dec_s.ctrl = ALU_ADD;
            default:                    dec_s.ill = 1'b1;
        endcase
    end

    bundle_t out_r, out_nxt_s;
    bundle_t skid_r, skid_nxt_s;
    logic    out_valid_r, out_valid_nxt_s;
    logic    skid_valid_r, skid_valid_nxt_s;
    logic    in_ready_r;
    logic    in_xfer_s, out_load_s;

    assign in_xfer_s  = in_valid & in_ready_r;
    assign out_load_s = ~out_valid_r | out_ready;

    // Next-state for output and skid registers; flush only clears valid bits
    always_comb begin
        out_nxt_s        = out_r;
        skid_nxt_s       = skid_r;
        out_valid_nxt_s  = out_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        if (flush) begin
            out_valid_nxt_s  = 1'b0;
            skid_valid_nxt_s = 1'b0;
        end else begin
            if (out_load_s) begin
                if (skid_valid_r) begin
                    out_nxt_s       = skid_r;
                    out_valid_nxt_s = 1'b1;
                end else if (in_xfer_s) begin
                    out_nxt_s       = dec_s;
                    out_valid_nxt_s = 1'b1;
                end else begin
                    out_valid_nxt_s = 1'b0;
                end
            end else begin
                out_valid_nxt_s = out_valid_r;
            end
            // Skid takes the input whenever it cannot go straight to the output
            if (in_xfer_s & (~out_load_s | skid_valid_r)) begin
                skid_nxt_s       = dec_s;
                skid_valid_nxt_s = 1'b1;
            end else if (out_load_s & skid_valid_r) begin
                skid_valid_nxt_s = 1'b0;
            end else begin
                skid_valid_nxt_s = skid_valid_r;
            end
        end
    end

    // Pipeline state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r        <= BUNDLE_ZERO;
            skid_r       <= BUNDLE_ZERO;
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            out_r        <= out_nxt_s;
            skid_r       <= skid_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            in_ready_r   <= ~skid_valid_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign alu_a     = out_r.a;
    assign alu_b     = out_r.b;
    assign alu_ctrl  = out_r.ctrl;
    assign is_branch = out_r.br;
    assign illegal   = out_r.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: driver pushes expected bundles on acceptance,
// monitor compares and pops on the output side.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic        br;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'd0, pc = 32'd0, rs1_data = 32'd0, rs2_data = 32'd0, imm = 32'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_ctrl;
    logic        is_branch, illegal;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t pend;
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
    int   stall_cnt = 0;
    bit   rand_flush = 1'b0;

    logic [3:0] op_tab [8] = '{4'd0, 4'd6, 4'd5, 4'd8, 4'd4, 4'd7, 4'd3, 4'd2};
    logic [3:0] br_tab [4] = '{4'd1, 4'd0, 4'd5, 4'd8};
    logic [6:0] opc_tab [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctrl(alu_ctrl), .is_branch(is_branch), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] i, p, r1, r2, im);
        exp_t e;
        logic [6:0] op = i[6:0];
        logic [2:0] f3 = i[14:12];
        logic       f7 = i[30];
        e = '{a: r1, b: im, ctrl: 4'd0, br: 1'b0, ill: 1'b0};
        if (op == 7'h33 || op == 7'h13) begin
            e.ctrl = op_tab[f3];
            if (f7 && f3 == 3'd5) e.ctrl = 4'd9;
            if (op == 7'h33) begin
                e.b = r2;
                if (f7 && f3 == 3'd0) e.ctrl = 4'd1;
            end else if (f7 && f3 == 3'd1) begin
                e.ill = 1'b1;
            end
        end else if (op == 7'h63) begin
            e.b  = r2;
            e.br = 1'b1;
            if (f3[2:1] == 2'b01) e.ill = 1'b1;
            else e.ctrl = br_tab[f3[2:1]];
        end else if (op == 7'h37) begin
            e.a = 32'd0;
        end else if (op == 7'h17 || op == 7'h6F) begin
            e.a = p;
        end else if (op != 7'h03 && op != 7'h23 && op != 7'h67) begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    // Monitor: occupancy-derived handshake checks plus in-order data compare
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (out_valid !== (sb.size() > 0)) begin
                errors++;
                $display("FAIL out_valid: got %b want %b", out_valid, sb.size() > 0);
            end
            checks++;
            if (in_ready !== (sb.size() < 2)) begin
                errors++;
                $display("FAIL in_ready: got %b want %b", in_ready, sb.size() < 2);
            end
            if (out_valid && sb.size() > 0) begin
                checks++;
                if ({alu_a, alu_b, alu_ctrl, is_branch, illegal} !== sb[0]) begin
                    errors++;
                    $display("FAIL data: got a=%h b=%h ctrl=%h br=%b ill=%b want a=%h b=%h ctrl=%h br=%b ill=%b",
                             alu_a, alu_b, alu_ctrl, is_branch, illegal,
                             sb[0].a, sb[0].b, sb[0].ctrl, sb[0].br, sb[0].ill);
                end
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic step(output bit acc);
        bit fl;
        @(negedge clk);
        acc = in_valid && in_ready;
        fl  = flush;
        @(posedge clk);
        if (fl) sb.delete();
        else if (acc) sb.push_back(pend);
        #1;
        flush = rand_flush ? ($urandom_range(0, 39) == 0) : 1'b0;
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else begin
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    endtask

    task automatic send(input logic [31:0] i, p, r1, r2, im, input exp_t e);
        bit acc;
        int n = 0;
        instr = i; pc = p; rs1_data = r1; rs2_data = r2; imm = im;
        pend = e;
        in_valid = 1'b1;
        do begin
            step(acc);
            n++;
        end while (!acc && n < 50);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: instr=%h not accepted within %0d cycles", i, n);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [31:0] i, p, r1, r2, im);
        send(i, p, r1, r2, im, model(i, p, r1, r2, im));
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        ready_mode = 0;
        stall_cnt  = 0;
        out_ready  = 1'b1;
        while (sb.size() > 0 && n < 40) begin
            step(acc);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d entries left", sb.size());
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            {alu_a, alu_b, alu_ctrl, is_branch, illegal} !== 70'd0) begin
            errors++;
            $display("FAIL %s: got v=%b rdy=%b a=%h b=%h ctrl=%h br=%b ill=%b want v=0 rdy=1 data=0",
                     name, out_valid, in_ready, alu_a, alu_b, alu_ctrl, is_branch, illegal);
        end
    endtask

    initial begin
        logic [31:0] ri;
        bit acc;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_state");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // R-type sub, then decode sweep with spec-given expectations
        send(32'h402081B3, 32'h0, 32'd10, 32'd3, 32'h0,
             '{a: 32'd10, b: 32'd3, ctrl: 4'b0001, br: 1'b0, ill: 1'b0});
        send(32'h40305093, 32'h0, 32'hF000_0000, 32'd7, 32'd3,
             '{a: 32'hF000_0000, b: 32'd3, ctrl: 4'b1001, br: 1'b0, ill: 1'b0});
        send(32'h0020E063, 32'h40, 32'd5, 32'd9, 32'h10,
             '{a: 32'd5, b: 32'd9, ctrl: 4'b1000, br: 1'b1, ill: 1'b0});
        send(32'h123450B7, 32'h80, 32'd55, 32'd66, 32'h12345000,
             '{a: 32'd0, b: 32'h12345000, ctrl: 4'b0000, br: 1'b0, ill: 1'b0});
        send(32'h00002097, 32'h100, 32'd77, 32'd88, 32'h2000,
             '{a: 32'h100, b: 32'h2000, ctrl: 4'b0000, br: 1'b0, ill: 1'b0});
        send(32'h0000007F, 32'h0, 32'd11, 32'd22, 32'h33,
             '{a: 32'd11, b: 32'h33, ctrl: 4'b0000, br: 1'b0, ill: 1'b1});
        drain();

        // Back-pressure: three stall cycles right after I0 reaches the output
        send_m(32'h00208033, 32'h0, 32'd100, 32'd1, 32'd0);
        out_ready = 1'b0;
        stall_cnt = 2;
        for (int k = 1; k < 5; k++)
            send_m(32'h00000013 | (32'(k) << 12), 32'h0, 32'd100 + 32'(k), 32'd2, 32'd50 + 32'(k));
        drain();

        // Flush with output and skid both full and an input pending
        ready_mode = 2;
        out_ready  = 1'b0;
        send_m(32'h00000033, 32'h0, 32'd1, 32'd2, 32'd0);
        send_m(32'h00004033, 32'h0, 32'd3, 32'd4, 32'd0);
        instr = 32'h0000007F; rs1_data = 32'hDEAD; imm = 32'hBEEF;
        in_valid = 1'b1;
        flush    = 1'b1;
        step(acc);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        ready_mode = 0;
        out_ready  = 1'b1;
        send_m(32'h00007033, 32'h0, 32'd5, 32'd6, 32'd0);
        drain();

        // Randomized traffic with random back-pressure and occasional flush
        ready_mode = 1;
        rand_flush = 1'b1;
        for (int k = 0; k < 300; k++) begin
            ri = $urandom();
            if ($urandom_range(0, 9) != 0) ri[6:0] = opc_tab[$urandom_range(0, 8)];
            send_m(ri, $urandom(), $urandom(), $urandom(), $urandom());
        end
        rand_flush = 1'b0;
        flush      = 1'b0;
        drain();

        // Asynchronous reset between edges while output is held
        ready_mode = 2;
        out_ready  = 1'b0;
        send_m(32'h00A00093, 32'h0, 32'hAAAA, 32'h0, 32'hA);
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_reset");
        sb.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        ready_mode = 0;
        out_ready  = 1'b1;
        send_m(32'h00110113, 32'h0, 32'd8, 32'd0, 32'd1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
